// File: rtl/vga_rect_writer.sv
// vga_rect_writer
// Framebuffer writer for the 160x120, 3-bit-colour VGA pixel path. It takes
// rectangle-fill and clear-screen commands over a valid/ready handshake. It
// produces one pixel write per clock into the write port of the video memory.
//
// Ports
//    clk        system (pixel-domain) clock
//    reset      synchronous, active-high reset
//    cmd_valid  command present
//    cmd_ready  block can accept a command (high only in IDLE)
//    cmd_clear  1 = fill the whole screen; x/y/w/h are ignored
//    cmd_x      rectangle left column
//    cmd_y      rectangle top row
//    cmd_w      rectangle width in pixels
//    cmd_h      rectangle height in pixels
//    cmd_color  fill colour
//    wr_en      pixel write strobe
//    wr_x       write column
//    wr_y       write row
//    wr_color   write colour
//    busy       command in progress
//    done       one-cycle pulse when a command completes
module vga_rect_writer #(
   parameter int H_RES = 160,
   parameter int V_RES = 120,
   parameter int XW    = 8,
   parameter int YW    = 7,
   parameter int CW    = 3
) (
   input  logic          clk,
   input  logic          reset,
   input  logic          cmd_valid,
   output logic          cmd_ready,
   input  logic          cmd_clear,
   input  logic [XW-1:0] cmd_x,
   input  logic [YW-1:0] cmd_y,
   input  logic [XW-1:0] cmd_w,
   input  logic [YW-1:0] cmd_h,
   input  logic [CW-1:0] cmd_color,
   output logic          wr_en,
   output logic [XW-1:0] wr_x,
   output logic [YW-1:0] wr_y,
   output logic [CW-1:0] wr_color,
   output logic          busy,
   output logic          done
);

   // Screen limits held one bit wider than the coordinate fields, so that
   // the clipped end coordinates (which can equal the resolution) fit.
   localparam logic [XW:0] X_LIM = (XW+1)'(H_RES);
   localparam logic [YW:0] Y_LIM = (YW+1)'(V_RES);

   typedef enum logic [1:0] {
      IDLE,
      FILL,
      DONE
   } state_t;

   state_t state;

   // Latched rectangle geometry. wr_x / wr_y double as the scan cursor.
   logic [XW-1:0] x0_q;
   logic [XW:0]   x_end_q;
   logic [YW:0]   y_end_q;

   // Effective command fields after clear substitution, the clipped
   // exclusive end coordinates and the zero-write classification. Sums are
   // one bit wider, so x + w cannot wrap back onto the screen.
   logic [XW-1:0] eff_x0;
   logic [YW-1:0] eff_y0;
   logic [XW-1:0] eff_w;
   logic [YW-1:0] eff_h;
   logic [XW:0]   sum_x;
   logic [YW:0]   sum_y;
   logic [XW:0]   x_end_c;
   logic [YW:0]   y_end_c;
   logic          degenerate;

   always_comb begin
      eff_x0     = cmd_clear ? '0 : cmd_x;
      eff_y0     = cmd_clear ? '0 : cmd_y;
      eff_w      = cmd_clear ? X_LIM[XW-1:0] : cmd_w;
      eff_h      = cmd_clear ? Y_LIM[YW-1:0] : cmd_h;
      sum_x      = {1'b0, eff_x0} + {1'b0, eff_w};
      sum_y      = {1'b0, eff_y0} + {1'b0, eff_h};
      x_end_c    = (sum_x > X_LIM) ? X_LIM : sum_x;
      y_end_c    = (sum_y > Y_LIM) ? Y_LIM : sum_y;
      degenerate = (eff_w == '0) || (eff_h == '0) ||
                   ({1'b0, eff_x0} >= X_LIM) || ({1'b0, eff_y0} >= Y_LIM);
   end

   // The cursor sits on the last column / last row of the clipped rectangle.
   logic last_col;
   logic last_row;

   always_comb begin
      last_col = ({1'b0, wr_x} == (x_end_q - 1'b1));
      last_row = ({1'b0, wr_y} == (y_end_q - 1'b1));
   end

   // Main FSM. A command is latched on accept; a non-empty rectangle is
   // then scanned row-major with one registered write per clock, and every
   // command ends with a single DONE cycle before returning to IDLE.
   always_ff @(posedge clk) begin
      if (reset) begin
         state    <= IDLE;
         wr_en    <= 1'b0;
         wr_x     <= '0;
         wr_y     <= '0;
         wr_color <= '0;
         done     <= 1'b0;
         x0_q     <= '0;
         x_end_q  <= '0;
         y_end_q  <= '0;
      end else begin
         case (state)
            IDLE: begin
               wr_en <= 1'b0;
               done  <= 1'b0;
               if (cmd_valid) begin
                  if (degenerate) begin
                     state <= DONE;
                     done  <= 1'b1;
                  end else begin
                     state    <= FILL;
                     wr_en    <= 1'b1;
                     wr_x     <= eff_x0;
                     wr_y     <= eff_y0;
                     wr_color <= cmd_color;
                     x0_q     <= eff_x0;
                     x_end_q  <= x_end_c;
                     y_end_q  <= y_end_c;
                  end
               end
            end
            FILL: begin
               if (last_col) begin
                  if (last_row) begin
                     state <= DONE;
                     wr_en <= 1'b0;
                     done  <= 1'b1;
                  end else begin
                     wr_x <= x0_q;
                     wr_y <= wr_y + 1'b1;
                  end
               end else begin
                  wr_x <= wr_x + 1'b1;
               end
            end
            DONE: begin
               state <= IDLE;
               done  <= 1'b0;
               wr_en <= 1'b0;
            end
            default: begin
               state <= IDLE;
               wr_en <= 1'b0;
               done  <= 1'b0;
            end
         endcase
      end
   end

   // Handshake and status follow directly from the registered state.
   assign cmd_ready = (state == IDLE);
   assign busy      = (state != IDLE);

endmodule
